memory_unit: RTL and testbench

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit_pkg.sv | 20 ++
 rtl/mem_array.sv | 33 +++
 rtl/memory_unit.sv | 146 ++++++++++++++
 tb/tb_memory_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/memory_unit_pkg.sv
// Shared definitions for memory_unit: FSM state encoding, operation codes and default sizing.
package memory_unit_pkg;

    localparam int DEF_ADDR_BITS   = 8;
    localparam int DEF_WAIT_CYCLES = 3;
    localparam int DATA_BITS       = 16;
    localparam int CNT_BITS        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_array.sv
// Word storage for memory_unit: synchronous write, registered read port (read register clears on rst).
module mem_array
    import memory_unit_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    // NOTE: the storage array is deliberately not reset, so it maps onto plain RAM; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_unit.sv
// CPU-side memory unit: rd/wr level handshake with MFC, optional wait states (MEMORY_UNIT_WAIT_EN).
// ADDR_BITS must be 1..15; WAIT_CYCLES (1..15) only matters when MEMORY_UNIT_WAIT_EN is defined.
module memory_unit
    import memory_unit_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [15:0]          addr,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 MFC,
    output logic                 err
);

    state_t               state, state_next;
    logic                 err_next;
    logic                 acc_re, acc_we;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [DATA_BITS-1:0] acc_din;

`ifdef MEMORY_UNIT_WAIT_EN
    logic [CNT_BITS-1:0]  cnt_q, cnt_next;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] din_q;
    op_t                  op_q;

    logic unused_bits;
    assign unused_bits = ^addr[15:ADDR_BITS];
`else
    logic unused_bits;
    assign unused_bits = ^{addr[15:ADDR_BITS], 4'(WAIT_CYCLES)};
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        acc_re     = 1'b0;
        acc_we     = 1'b0;
        acc_addr   = addr[ADDR_BITS-1:0];
        acc_din    = din;
`ifdef MEMORY_UNIT_WAIT_EN
        cnt_next   = cnt_q;
`endif

        case (state)
            IDLE: begin
                if (rd && wr) begin
                    err_next = 1'b1;
                end else if (rd || wr) begin
`ifdef MEMORY_UNIT_WAIT_EN
                    if (WAIT_CYCLES > 1) begin
                        state_next = WAIT;
                        cnt_next   = CNT_BITS'(WAIT_CYCLES - 1);
                    end else begin
                        state_next = ACK;
                        acc_re     = rd;
                        acc_we     = wr;
                    end
`else
                    state_next = ACK;
                    acc_re     = rd;
                    acc_we     = wr;
`endif
                end
            end
`ifdef MEMORY_UNIT_WAIT_EN
            WAIT: begin
                // The latched request governs; live addr/din may already have moved on.
                acc_addr = addr_q;
                acc_din  = din_q;
                if (!rd && !wr) begin
                    state_next = IDLE;
                end else if (cnt_q == '0) begin
                    state_next = ACK;
                    acc_re     = (op_q == OP_RD);
                    acc_we     = (op_q == OP_WR);
                end else begin
                    cnt_next = cnt_q - CNT_BITS'(1);
                end
            end
`endif
            ACK: begin
                if (!rd && !wr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Reset wins over an access that would otherwise complete on this edge.
        if (rst) begin
            acc_re = 1'b0;
            acc_we = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            MFC   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            MFC   <= (state_next == ACK);
            err   <= err_next;
        end
    end

`ifdef MEMORY_UNIT_WAIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && (rd ^ wr)) begin
            addr_q <= addr[ADDR_BITS-1:0];
            din_q  <= din;
            op_q   <= wr ? OP_WR : OP_RD;
        end
    end
`endif

    mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (acc_we),
        .re   (acc_re),
        .addr (acc_addr),
        .wdata(acc_din),
        .rdata(dout)
    );

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit; expected latency follows MEMORY_UNIT_WAIT_EN.
module tb_memory_unit;

    localparam int WAIT_CYCLES = 3;
`ifdef MEMORY_UNIT_WAIT_EN
    localparam int LAT = WAIT_CYCLES;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd  = 1'b0;
    logic        wr  = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] din  = '0;
    logic [15:0] dout;
    logic        MFC;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    memory_unit #(
        .ADDR_BITS  (8),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rd  (rd),
        .wr  (wr),
        .addr(addr),
        .din (din),
        .dout(dout),
        .MFC (MFC),
        .err (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble addr/din after it is sampled, and wait (bounded) for MFC.
    task automatic access(input logic is_wr, input logic [15:0] a, input logic [15:0] d,
                          input string tag);
        int n;
        rd   = !is_wr;
        wr   = is_wr;
        addr = a;
        din  = d;
        n    = 0;
        tick();
        addr = ~a;
        din  = ~d;
        while (!MFC && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, LAT);
    endtask

    task automatic release_req(input string tag);
        rd = 1'b0;
        wr = 1'b0;
        tick();
        check({tag, " mfc low"}, MFC, 1'b0);
    endtask

    initial begin
        int hi_cnt;

        tick();
        tick();
        check("reset mfc", MFC, 1'b0);
        check("reset err", err, 1'b0);
        check("reset dout", dout, 16'h0000);
        rst = 1'b0;
        tick();

        // Write then read back through the same word
        access(1'b1, 16'h0012, 16'hBEEF, "wr12");
        release_req("wr12");
        access(1'b0, 16'h0012, 16'h0000, "rd12");
        check("rd12 dout", dout, 16'hBEEF);
        release_req("rd12");

        // A write leaves dout untouched
        access(1'b1, 16'h0005, 16'h5A5A, "wr05");
        check("wr05 dout kept", dout, 16'hBEEF);
        release_req("wr05");
        access(1'b0, 16'h0005, 16'h0000, "rd05");
        check("rd05 dout", dout, 16'h5A5A);
        release_req("rd05");

        // Boundary words 0x00 and 0xFF
        access(1'b1, 16'h0000, 16'hFFFF, "wr00");
        release_req("wr00");
        access(1'b1, 16'h00FF, 16'h0001, "wrff");
        release_req("wrff");
        access(1'b0, 16'h0000, 16'h0000, "rd00");
        check("rd00 dout", dout, 16'hFFFF);
        release_req("rd00");
        access(1'b0, 16'h00FF, 16'h0000, "rdff");
        check("rdff dout", dout, 16'h0001);
        release_req("rdff");

        // Illegal request: rd and wr together in IDLE
        rd   = 1'b1;
        wr   = 1'b1;
        addr = 16'h0012;
        din  = 16'h0000;
        tick();
        check("illegal err", err, 1'b1);
        check("illegal mfc", MFC, 1'b0);
        rd = 1'b0;
        wr = 1'b0;
        tick();
        check("illegal err pulse", err, 1'b0);
        check("illegal mfc after", MFC, 1'b0);
        access(1'b0, 16'h0012, 16'h0000, "rd12 post-illegal");
        check("post-illegal dout", dout, 16'hBEEF);
        release_req("rd12 post-illegal");

`ifdef MEMORY_UNIT_WAIT_EN
        access(1'b1, 16'h0020, 16'h1111, "wr20");
        release_req("wr20");

        // Abort: write dropped one cycle into WAIT
        wr   = 1'b1;
        addr = 16'h0020;
        din  = 16'h1234;
        tick();
        tick();
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort mfc", MFC, 1'b0);
        end
        access(1'b0, 16'h0020, 16'h0000, "rd20 post-abort");
        check("post-abort dout", dout, 16'h1111);
        release_req("rd20 post-abort");

        // Reset two edges into a write
        wr   = 1'b1;
        addr = 16'h0020;
        din  = 16'hDEAD;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst-wait mfc", MFC, 1'b0);
        check("rst-wait dout", dout, 16'h0000);
        rst = 1'b0;
        wr  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rst-wait mfc idle", MFC, 1'b0);
        access(1'b0, 16'h0020, 16'h0000, "rd20 post-reset");
        check("post-reset dout", dout, 16'h1111);
        release_req("rd20 post-reset");
`endif

        // Upper address bits alias; hold rd through ACK
        access(1'b0, 16'hFF12, 16'h0000, "rdff12");
        check("alias dout", dout, 16'hBEEF);
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (MFC) hi_cnt++;
        end
        check("hold mfc cycles", hi_cnt, 10);
        check("hold dout", dout, 16'hBEEF);
        release_req("hold");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
